// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port memory between the I-cache miss port (read-only)
//   and the D-cache port (read-fill and write-through). Only one transaction
//   is in flight at a time. When both sides request in the same IDLE cycle,
//   round-robin arbitration picks the side that was not granted last, so
//   neither side can starve the other. Every output is registered.
//
// Parameters
//   MEM_LAT    memory read latency (cycles from mem_en to valid mem_rdata),
//              legal range 1..7
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_req      I-side read request (level, held until i_ack)
//   i_addr     I-side word address
//   i_rdata    I-side read data, qualified by i_ack
//   i_ack      I-side completion pulse (one cycle)
//   d_req      D-side request (level, held until d_ack)
//   d_we       D-side write (1) / read (0)
//   d_addr     D-side address
//   d_wdata    D-side write data, already byte-merged
//   d_be       D-side byte enables for writes
//   d_rdata    D-side read data, qualified by d_ack
//   d_ack      D-side completion pulse (one cycle)
//   mem_en     memory access strobe, one cycle per transaction
//   mem_we     memory write enable, qualified by mem_en
//   mem_be     memory byte enables (4'hF on reads)
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid MEM_LAT cycles after mem_en
//   busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,

    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        SIDE_I,
        SIDE_D
    } side_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t     state;
    side_t      grant;       // side owning the current transaction
    side_t      last_grant;  // side granted most recently, for round-robin
    logic [2:0] wait_cnt;
    logic       pick_d;

    // D wins when it is the only requester, or on a tie when I was served last.
    always_comb begin
        pick_d = d_req && (!i_req || (last_grant == SIDE_I));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= SIDE_I;
            last_grant <= SIDE_I;
            wait_cnt   <= '0;
            i_rdata    <= '0;
            i_ack      <= 1'b0;
            d_rdata    <= '0;
            d_ack      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        // The mem_* registers double as the latched request
                        // fields, so later input changes cannot leak in.
                        state  <= ISSUE;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        if (pick_d) begin
                            grant      <= SIDE_D;
                            last_grant <= SIDE_D;
                            mem_addr   <= d_addr;
                            mem_we     <= d_we;
                            mem_wdata  <= d_wdata;
                            mem_be     <= d_we ? d_be : 4'hF;
                        end else begin
                            grant      <= SIDE_I;
                            last_grant <= SIDE_I;
                            mem_addr   <= i_addr;
                            mem_we     <= 1'b0;
                            mem_be     <= 4'hF;
                        end
                    end
                end

                ISSUE: begin
                    mem_en <= 1'b0;
                    if (mem_we) begin
                        // Writes complete without waiting for the memory.
                        state <= RESP;
                        if (grant == SIDE_D) begin
                            d_ack <= 1'b1;
                        end else begin
                            i_ack <= 1'b1;
                        end
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= LAT;
                    end
                end

                WAIT: begin
                    // wait_cnt==1 marks the cycle in which mem_rdata is valid;
                    // capture it and raise ack for the following cycle.
                    if (wait_cnt <= 3'd1) begin
                        wait_cnt <= '0;
                        state    <= RESP;
                        if (grant == SIDE_D) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end

                RESP: begin
                    // Requests seen here are ignored; arbitration resumes in IDLE.
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Two instances: MEM_LAT=1 (most tests)
//   and MEM_LAT=3 (latency test). Each instance has a small memory model
//   that drives a poison value whenever read data is not due, so a wrong
//   capture cycle is visible.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // ---------------- instance 1 (MEM_LAT=1) ----------------
    logic        i_req, i_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  d_be, mem_be;

    dmem_arbiter #(.MEM_LAT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // ---------------- instance 3 (MEM_LAT=3) ----------------
    logic        i3_req, i3_ack, d3_req, d3_we, d3_ack, mem3_en, mem3_we, busy3;
    logic [31:0] i3_addr, i3_rdata, d3_addr, d3_wdata, d3_rdata;
    logic [31:0] mem3_addr, mem3_wdata, mem3_rdata;
    logic [3:0]  d3_be, mem3_be;

    dmem_arbiter #(.MEM_LAT(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i3_req),
        .i_addr    (i3_addr),
        .i_rdata   (i3_rdata),
        .i_ack     (i3_ack),
        .d_req     (d3_req),
        .d_we      (d3_we),
        .d_addr    (d3_addr),
        .d_wdata   (d3_wdata),
        .d_be      (d3_be),
        .d_rdata   (d3_rdata),
        .d_ack     (d3_ack),
        .mem_en    (mem3_en),
        .mem_we    (mem3_we),
        .mem_be    (mem3_be),
        .mem_addr  (mem3_addr),
        .mem_wdata (mem3_wdata),
        .mem_rdata (mem3_rdata),
        .busy      (busy3)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:255];
    logic        loaded = 1'b0;
    logic        r1_v = 1'b0;
    logic [31:0] r1_d;
    logic [2:0]  r3_v = '0;
    logic [31:0] r3_d [0:2];

    assign mem_rdata  = r1_v     ? r1_d    : 32'hBAD0BAD0;
    assign mem3_rdata = r3_v[2]  ? r3_d[2] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (!loaded) begin
            mem1[10'h100] <= 32'hDEADBEEF;
            mem1[10'h040] <= 32'hAABBCCDD;
            mem1[10'h104] <= 32'h11112222;
            mem1[10'h200] <= 32'h01010101;
            mem1[10'h300] <= 32'h02020202;
            mem3[8'h80]   <= 32'hA5A5A5A5;
            loaded        <= 1'b1;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem1[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        r1_v    <= mem_en && !mem_we;
        r1_d    <= mem1[mem_addr[9:0]];
        r3_v    <= {r3_v[1:0], mem3_en && !mem3_we};
        r3_d[0] <= mem3[mem3_addr[7:0]];
        r3_d[1] <= r3_d[0];
        r3_d[2] <= r3_d[1];
    end

    // ---------------- checking ----------------
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        i3_req = 0; i3_addr = '0; d3_req = 0; d3_we = 0; d3_addr = '0; d3_wdata = '0; d3_be = '0;
        tick(); tick();

        // Reset state
        chk("rst_busy",   busy,     0);
        chk("rst_mem_en", mem_en,   0);
        chk("rst_i_ack",  i_ack,    0);
        chk("rst_d_ack",  d_ack,    0);
        chk("rst_irdata", i_rdata,  0);
        chk("rst_mbe",    mem_be,   0);
        chk("rst_busy3",  busy3,    0);

        rst_n = 1'b1;
        tick();

        // Test 1: I read, MEM_LAT=1
        i_req = 1; i_addr = 32'h100;
        tick();                                          // T+1
        chk("t1_mem_en",  mem_en,   1);
        chk("t1_addr",    mem_addr, 32'h100);
        chk("t1_we",      mem_we,   0);
        chk("t1_be",      mem_be,   4'hF);
        chk("t1_busy",    busy,     1);
        tick();                                          // T+2
        chk("t1_en_off",  mem_en,   0);
        chk("t1_noack",   i_ack,    0);
        tick();                                          // T+3
        chk("t1_ack",     i_ack,    1);
        chk("t1_rdata",   i_rdata,  32'hDEADBEEF);
        chk("t1_no_dack", d_ack,    0);
        i_req = 0;
        tick();                                          // T+4
        chk("t1_ack_off", i_ack,    0);
        chk("t1_idle",    busy,     0);

        // Test 2: D write
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'b0011;
        tick();                                          // T+1
        chk("t2_mem_en",  mem_en,   1);
        chk("t2_we",      mem_we,   1);
        chk("t2_be",      mem_be,   4'b0011);
        chk("t2_addr",    mem_addr, 32'h40);
        chk("t2_wdata",   mem_wdata, 32'h12345678);
        tick();                                          // T+2
        chk("t2_dack",    d_ack,    1);
        chk("t2_no_iack", i_ack,    0);
        chk("t2_drdata",  d_rdata,  0);
        chk("t2_merge",   mem1[10'h040], 32'hAABB5678);
        d_req = 0; d_we = 0;
        tick();
        chk("t2_ack_off", d_ack,    0);

        // Test 6: D write, in RESP d_req drops and i_req rises
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hCAFEF00D; d_be = 4'hF;
        tick();                                          // T+1
        chk("t6_we",      mem_we,   1);
        tick();                                          // T+2
        chk("t6_dack",    d_ack,    1);
        d_req = 0; d_we = 0; i_req = 1; i_addr = 32'h104;
        tick();                                          // T+3 IDLE
        chk("t6_idle_en", mem_en,   0);
        chk("t6_idle",    busy,     0);
        tick();                                          // T+4
        chk("t6_mem_en",  mem_en,   1);
        chk("t6_addr",    mem_addr, 32'h104);
        chk("t6_we_rd",   mem_we,   0);
        tick(); tick();                                  // T+6
        chk("t6_iack",    i_ack,    1);
        chk("t6_irdata",  i_rdata,  32'h11112222);
        chk("t6_no_dack", d_ack,    0);
        i_req = 0;
        tick();

        // Test 5: reset during WAIT of an I read
        i_req = 1; i_addr = 32'h100;
        tick(); tick();                                  // in WAIT
        rst_n = 0; i_req = 0; d_req = 1; d_we = 0; d_addr = 32'h300;
        #1;
        chk("t5_busy",    busy,     0);
        chk("t5_mem_en",  mem_en,   0);
        chk("t5_irdata",  i_rdata,  0);
        chk("t5_maddr",   mem_addr, 0);
        chk("t5_iack",    i_ack,    0);
        tick(); tick();
        rst_n = 1;
        tick();                                          // R+1
        chk("t5_d_en",    mem_en,   1);
        chk("t5_d_addr",  mem_addr, 32'h300);
        tick();                                          // R+2
        chk("t5_no_iack", i_ack,    0);
        tick();                                          // R+3
        chk("t5_dack",    d_ack,    1);
        chk("t5_drdata",  d_rdata,  32'h02020202);
        chk("t5_no_iack2", i_ack,   0);
        d_req = 0;
        tick();

        // Test 3: both read continuously from reset -> D, I, D
        rst_n = 0; i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h200; d_addr = 32'h300;
        tick();
        rst_n = 1;
        tick();                                          // T+1
        chk("t3_g1_addr", mem_addr, 32'h300);
        tick(); tick();                                  // T+3
        chk("t3_dack",    d_ack,    1);
        chk("t3_drdata",  d_rdata,  32'h02020202);
        chk("t3_no_iack", i_ack,    0);
        tick(); tick();                                  // T+5
        chk("t3_g2_en",   mem_en,   1);
        chk("t3_g2_addr", mem_addr, 32'h200);
        tick(); tick();                                  // T+7
        chk("t3_iack",    i_ack,    1);
        chk("t3_irdata",  i_rdata,  32'h01010101);
        chk("t3_no_dack", d_ack,    0);
        tick(); tick();                                  // T+9
        chk("t3_g3_addr", mem_addr, 32'h300);
        tick(); tick();                                  // T+11
        chk("t3_dack2",   d_ack,    1);
        chk("t3_no_iack2", i_ack,   0);
        i_req = 0; d_req = 0;
        tick(); tick();
        chk("t3_idle",    busy,     0);

        // Test 4: MEM_LAT=3 D read
        d3_req = 1; d3_we = 0; d3_addr = 32'h80;
        tick();                                          // T+1
        chk("t4_mem_en",  mem3_en,  1);
        chk("t4_busy1",   busy3,    1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("t4_busy_w",  busy3,   1);
            chk("t4_noack_w", d3_ack,  0);
            chk("t4_en_w",    mem3_en, 0);
        end
        tick();                                          // T+5
        chk("t4_dack",    d3_ack,   1);
        chk("t4_drdata",  d3_rdata, 32'hA5A5A5A5);
        chk("t4_busy5",   busy3,    1);
        chk("t4_no_iack", i3_ack,   0);
        d3_req = 0;
        tick();                                          // T+6
        chk("t4_idle",    busy3,    0);
        chk("t4_ack_off", d3_ack,   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
